// File: rtl/noun_mem_responder.sv
// noun_mem_responder
// Memory-side responder for the noun store. Accepts one request at a time on
// a rising edge of mem_execute and runs it against an internal single-port
// synchronous RAM. It answers with a one-cycle mem_ready pulse and registered
// read data. It also owns the bump allocator that hands out fresh addresses.
//
// Ports:
//   clk          - single clock, all state changes on the rising edge
//   rst          - asynchronous active-high reset
//   mem_execute  - request strobe, only its rising edge starts a request
//   mem_func     - 00 NOP, 01 GET_CONTENTS, 10 SET_CONTENTS, 11 ALLOC
//   address1     - primary address (GET, SET)
//   address2     - secondary address (GET only)
//   write_data   - word stored by SET / ALLOC
//   mem_ready    - one-cycle completion pulse
//   read_data1   - GET: word at address1, ALLOC: allocated address (zero-extended)
//   read_data2   - GET: word at address2, otherwise held
//   free_addr    - next address ALLOC will hand out
//   mem_error    - sticky, bit0 = request dropped while busy, bit1 = ALLOC out of memory

module noun_mem_responder #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 64,
   parameter int FREE_BASE  = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mem_execute,
   input  logic [1:0]            mem_func,
   input  logic [ADDR_WIDTH-1:0] address1,
   input  logic [ADDR_WIDTH-1:0] address2,
   input  logic [DATA_WIDTH-1:0] write_data,
   output logic                  mem_ready,
   output logic [DATA_WIDTH-1:0] read_data1,
   output logic [DATA_WIDTH-1:0] read_data2,
   output logic [ADDR_WIDTH-1:0] free_addr,
   output logic [1:0]            mem_error
);

   typedef enum logic [2:0] {
      IDLE,
      RD1,
      RD2,
      WR,
      RESP
   } state_t;

   localparam logic [1:0] FUNC_NOP   = 2'b00;
   localparam logic [1:0] FUNC_GET   = 2'b01;
   localparam logic [1:0] FUNC_SET   = 2'b10;
   localparam logic [1:0] FUNC_ALLOC = 2'b11;

   localparam int                  DEPTH    = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] TOP_ADDR = '1;

   state_t                  state;
   state_t                  next_state;

   logic                    exec_q;
   logic [1:0]              func_q;
   logic [ADDR_WIDTH-1:0]   a1_q;
   logic [ADDR_WIDTH-1:0]   a2_q;
   logic [DATA_WIDTH-1:0]   wd_q;
   logic                    full;

   logic                    exec_rise;
   logic                    accept;
   logic                    alloc_oom;
   logic                    ram_we;
   logic [ADDR_WIDTH-1:0]   ram_addr;
   logic [DATA_WIDTH-1:0]   ram_q;
   logic [DATA_WIDTH-1:0]   ram [DEPTH];

   // A request starts only on a fresh rising edge of the strobe, only when we
   // are idle, and only for a real function. Holding the strobe high is one request.
   assign exec_rise = mem_execute & ~exec_q;
   assign accept    = exec_rise & (state == IDLE) & (mem_func != FUNC_NOP);

   // The top address has been handed out once free_addr has saturated there
   // and the full flag is set; any further ALLOC has nowhere to go.
   assign alloc_oom = full & (free_addr == TOP_ADDR);

   // State register for the request sequencer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic and the RAM port controls. The single RAM port is
   // shared: GET reads a1 then a2 on consecutive cycles, SET writes a1, and
   // ALLOC writes at the allocator pointer unless memory is exhausted.
   always_comb begin
      next_state = state;
      ram_we     = 1'b0;
      ram_addr   = a1_q;
      case (state)
         IDLE: begin
            if (accept) begin
               next_state = (mem_func == FUNC_GET) ? RD1 : WR;
            end
         end
         RD1: begin
            next_state = RD2;
         end
         RD2: begin
            ram_addr   = a2_q;
            next_state = RESP;
         end
         WR: begin
            next_state = RESP;
            if (func_q == FUNC_ALLOC) begin
               ram_addr = free_addr;
               ram_we   = ~alloc_oom;
            end else begin
               ram_we   = 1'b1;
            end
         end
         RESP: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Request latching, response registers, error flags and the bump allocator.
   // The RAM read lags its address by one cycle, so read_data1 is taken while
   // the sequencer sits in RD2 and read_data2 while it sits in RESP.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exec_q     <= 1'b0;
         func_q     <= FUNC_NOP;
         a1_q       <= '0;
         a2_q       <= '0;
         wd_q       <= '0;
         full       <= 1'b0;
         mem_ready  <= 1'b0;
         read_data1 <= '0;
         read_data2 <= '0;
         free_addr  <= ADDR_WIDTH'(FREE_BASE);
         mem_error  <= 2'b00;
      end else begin
         exec_q    <= mem_execute;
         mem_ready <= (state == RESP);

         if (accept) begin
            func_q <= mem_func;
            a1_q   <= address1;
            a2_q   <= address2;
            wd_q   <= write_data;
         end

         if (exec_rise && (state != IDLE)) begin
            mem_error[0] <= 1'b1;
         end

         case (state)
            RD2: begin
               read_data1 <= ram_q;
            end
            RESP: begin
               if (func_q == FUNC_GET) begin
                  read_data2 <= ram_q;
               end
            end
            WR: begin
               if (func_q == FUNC_ALLOC) begin
                  if (alloc_oom) begin
                     mem_error[1] <= 1'b1;
                     read_data1   <= '0;
                  end else begin
                     read_data1 <= DATA_WIDTH'(free_addr);
                     if (free_addr == TOP_ADDR) begin
                        full <= 1'b1;
                     end else begin
                        free_addr <= free_addr + ADDR_WIDTH'(1);
                     end
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Single-port synchronous RAM, read-first. Contents survive reset on purpose:
   // the store is only ever reinitialised by software writing it.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         ram[ram_addr] <= wd_q;
      end
      ram_q <= ram[ram_addr];
   end

endmodule

// File: tb/tb_noun_mem_responder.sv
// tb_noun_mem_responder
// Self-checking bench for noun_mem_responder. A 10-bit instance carries the
// main table of SET/GET/ALLOC vectors. A 3-bit instance shares the same
// stimulus bus and is examined only during the allocator exhaustion sequence.
// Both instances receive every request, so the 3-bit instance is reset
// before that sequence starts.

module tb_noun_mem_responder;

   localparam int AW  = 10;
   localparam int DW  = 64;
   localparam int AWS = 3;

   localparam logic [1:0] FUNC_NOP   = 2'b00;
   localparam logic [1:0] FUNC_GET   = 2'b01;
   localparam logic [1:0] FUNC_SET   = 2'b10;
   localparam logic [1:0] FUNC_ALLOC = 2'b11;

   localparam logic [DW-1:0] W42   = 64'h0000_0000_0000_0042;
   localparam logic [DW-1:0] WC0   = 64'h00C0_0000_1000_0000;
   localparam logic [DW-1:0] WDEAD = 64'hDEAD_BEEF_0123_4567;

   logic           clk = 1'b0;
   logic           rst;
   logic           mem_execute;
   logic [1:0]     mem_func;
   logic [AW-1:0]  address1;
   logic [AW-1:0]  address2;
   logic [DW-1:0]  write_data;

   logic           mem_ready;
   logic [DW-1:0]  read_data1;
   logic [DW-1:0]  read_data2;
   logic [AW-1:0]  free_addr;
   logic [1:0]     mem_error;

   logic           s_mem_ready;
   logic [DW-1:0]  s_read_data1;
   logic [DW-1:0]  s_read_data2;
   logic [AWS-1:0] s_free_addr;
   logic [1:0]     s_mem_error;

   int test_count = 0;
   int fail_count = 0;

   noun_mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FREE_BASE(1)) dut (
      .clk        (clk),
      .rst        (rst),
      .mem_execute(mem_execute),
      .mem_func   (mem_func),
      .address1   (address1),
      .address2   (address2),
      .write_data (write_data),
      .mem_ready  (mem_ready),
      .read_data1 (read_data1),
      .read_data2 (read_data2),
      .free_addr  (free_addr),
      .mem_error  (mem_error)
   );

   noun_mem_responder #(.ADDR_WIDTH(AWS), .DATA_WIDTH(DW), .FREE_BASE(1)) dut_small (
      .clk        (clk),
      .rst        (rst),
      .mem_execute(mem_execute),
      .mem_func   (mem_func),
      .address1   (address1[AWS-1:0]),
      .address2   (address2[AWS-1:0]),
      .write_data (write_data),
      .mem_ready  (s_mem_ready),
      .read_data1 (s_read_data1),
      .read_data2 (s_read_data2),
      .free_addr  (s_free_addr),
      .mem_error  (s_mem_error)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]    func;
      logic [AW-1:0] a1;
      logic [AW-1:0] a2;
      logic [DW-1:0] wd;
      int            lat;
      logic [DW-1:0] rd1;
      logic [DW-1:0] rd2;
      logic [AW-1:0] free;
   } vec_t;

   vec_t vecs[10];

   // Compare one observed value against its expected value and tally the result.
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      test_count++;
      if (act !== exp) begin
         fail_count++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request and wait (bounded) for mem_ready. lat is the number of
   // edges after the accept edge at which mem_ready was first seen, 0 if never.
   task automatic applyStimulus(input logic [1:0] func, input logic [AW-1:0] a1,
                                input logic [AW-1:0] a2, input logic [DW-1:0] wd,
                                output int lat);
      mem_func    = func;
      address1    = a1;
      address2    = a2;
      write_data  = wd;
      mem_execute = 1'b1;
      tick();
      mem_execute = 1'b0;
      lat = 0;
      for (int n = 1; n <= 10; n++) begin
         tick();
         if (mem_ready) begin
            lat = n;
            break;
         end
      end
   endtask

   initial begin
      int lat;
      int pulses;
      logic [DW-1:0] got1;
      logic [DW-1:0] got2;

      vecs[0] = '{FUNC_SET,   10'd5, 10'd0, W42,   2, 64'h0,  64'h0, 10'd1};
      vecs[1] = '{FUNC_SET,   10'd6, 10'd0, WC0,   2, 64'h0,  64'h0, 10'd1};
      vecs[2] = '{FUNC_GET,   10'd5, 10'd6, 64'h0, 3, W42,    WC0,   10'd1};
      vecs[3] = '{FUNC_ALLOC, 10'd0, 10'd0, 64'h1, 2, 64'h1,  WC0,   10'd2};
      vecs[4] = '{FUNC_ALLOC, 10'd0, 10'd0, 64'h2, 2, 64'h2,  WC0,   10'd3};
      vecs[5] = '{FUNC_ALLOC, 10'd0, 10'd0, 64'h3, 2, 64'h3,  WC0,   10'd4};
      vecs[6] = '{FUNC_GET,   10'd2, 10'd3, 64'h0, 3, 64'h2,  64'h3, 10'd4};
      vecs[7] = '{FUNC_GET,   10'd6, 10'd5, 64'h0, 3, WC0,    W42,   10'd4};
      vecs[8] = '{FUNC_SET,   10'd2, 10'd0, WDEAD, 2, WC0,    W42,   10'd4};
      vecs[9] = '{FUNC_GET,   10'd2, 10'd1, 64'h0, 3, WDEAD,  64'h1, 10'd4};

      rst         = 1'b1;
      mem_execute = 1'b0;
      mem_func    = FUNC_NOP;
      address1    = '0;
      address2    = '0;
      write_data  = '0;
      tick();
      tick();
      rst = 1'b0;
      tick();

      $display("[TB] reset state");
      checkOutput("rst_free",   64'(free_addr),   64'd1);
      checkOutput("rst_ready",  64'(mem_ready),   64'd0);
      checkOutput("rst_err",    64'(mem_error),   64'd0);
      checkOutput("rst_rd1",    read_data1,       64'd0);
      checkOutput("rst_rd2",    read_data2,       64'd0);
      checkOutput("rst_sfree",  64'(s_free_addr), 64'd1);

      $display("[TB] table vectors");
      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i].func, vecs[i].a1, vecs[i].a2, vecs[i].wd, lat);
         checkOutput($sformatf("v%0d_lat", i),  64'(lat),       64'(vecs[i].lat));
         checkOutput($sformatf("v%0d_rd1", i),  read_data1,     vecs[i].rd1);
         checkOutput($sformatf("v%0d_rd2", i),  read_data2,     vecs[i].rd2);
         checkOutput($sformatf("v%0d_free", i), 64'(free_addr), 64'(vecs[i].free));
         checkOutput($sformatf("v%0d_err", i),  64'(mem_error), 64'd0);
         tick();
         checkOutput($sformatf("v%0d_pulse", i), 64'(mem_ready), 64'd0);
      end

      $display("[TB] strobe held high for five edges");
      mem_func    = FUNC_GET;
      address1    = 10'd5;
      address2    = 10'd6;
      mem_execute = 1'b1;
      pulses      = 0;
      got1        = '0;
      got2        = '0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (i == 4) mem_execute = 1'b0;
         if (mem_ready) begin
            pulses++;
            got1 = read_data1;
            got2 = read_data2;
         end
      end
      checkOutput("hold_pulses", 64'(pulses),    64'd1);
      checkOutput("hold_rd1",    got1,           W42);
      checkOutput("hold_rd2",    got2,           WC0);
      checkOutput("hold_err",    64'(mem_error), 64'd0);

      $display("[TB] NOP edge ignored");
      mem_func    = FUNC_NOP;
      mem_execute = 1'b1;
      tick();
      mem_execute = 1'b0;
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (mem_ready) pulses++;
      end
      checkOutput("nop_pulses", 64'(pulses),    64'd0);
      checkOutput("nop_err",    64'(mem_error), 64'd0);

      $display("[TB] second edge while busy is dropped");
      mem_func    = FUNC_GET;
      address1    = 10'd2;
      address2    = 10'd3;
      mem_execute = 1'b1;
      tick();
      mem_execute = 1'b0;
      tick();
      mem_func    = FUNC_SET;
      address1    = 10'd2;
      address2    = 10'd5;
      write_data  = 64'hFFFF_FFFF_FFFF_FFFF;
      mem_execute = 1'b1;
      tick();
      checkOutput("drop_early_ready", 64'(mem_ready), 64'd0);
      checkOutput("drop_err",         64'(mem_error), 64'd1);
      mem_execute = 1'b0;
      tick();
      checkOutput("drop_ready", 64'(mem_ready), 64'd1);
      checkOutput("drop_rd1",   read_data1,     WDEAD);
      checkOutput("drop_rd2",   read_data2,     64'h3);
      tick();
      checkOutput("drop_pulse", 64'(mem_ready), 64'd0);
      applyStimulus(FUNC_GET, 10'd2, 10'd3, 64'h0, lat);
      checkOutput("drop_recheck_lat", 64'(lat),       64'd3);
      checkOutput("drop_recheck_rd1", read_data1,     WDEAD);
      checkOutput("drop_sticky_err",  64'(mem_error), 64'd1);
      tick();

      $display("[TB] allocator exhaustion on 3-bit instance");
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
      checkOutput("ex_rst_sfree", 64'(s_free_addr), 64'd1);
      checkOutput("ex_rst_err",   64'(mem_error),   64'd0);
      for (int i = 1; i <= 7; i++) begin
         applyStimulus(FUNC_ALLOC, 10'd0, 10'd0, 64'(i), lat);
         checkOutput($sformatf("ex%0d_sready", i), 64'(s_mem_ready),  64'd1);
         checkOutput($sformatf("ex%0d_srd1", i),   s_read_data1,      64'(i));
         checkOutput($sformatf("ex%0d_sfree", i),  64'(s_free_addr),  (i < 7) ? 64'(i + 1) : 64'd7);
         checkOutput($sformatf("ex%0d_serr", i),   64'(s_mem_error),  64'd0);
         tick();
      end
      applyStimulus(FUNC_ALLOC, 10'd0, 10'd0, 64'h8, lat);
      checkOutput("ex8_sready", 64'(s_mem_ready), 64'd1);
      checkOutput("ex8_srd1",   s_read_data1,     64'd0);
      checkOutput("ex8_sfree",  64'(s_free_addr), 64'd7);
      checkOutput("ex8_serr",   64'(s_mem_error), 64'd2);
      checkOutput("ex8_rd1",    read_data1,       64'd8);
      checkOutput("ex8_free",   64'(free_addr),   64'd9);
      tick();

      $display("[TB] reset in the middle of a GET");
      mem_func    = FUNC_GET;
      address1    = 10'd1;
      address2    = 10'd2;
      mem_execute = 1'b1;
      tick();
      mem_execute = 1'b0;
      tick();
      #2;
      rst = 1'b1;
      #1;
      checkOutput("mid_ready", 64'(mem_ready),   64'd0);
      checkOutput("mid_rd1",   read_data1,       64'd0);
      checkOutput("mid_rd2",   read_data2,       64'd0);
      checkOutput("mid_free",  64'(free_addr),   64'd1);
      checkOutput("mid_err",   64'(mem_error),   64'd0);
      checkOutput("mid_sfree", 64'(s_free_addr), 64'd1);
      checkOutput("mid_serr",  64'(s_mem_error), 64'd0);
      tick();
      rst = 1'b0;
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (mem_ready) pulses++;
      end
      checkOutput("mid_pulses", 64'(pulses), 64'd0);
      applyStimulus(FUNC_GET, 10'd1, 10'd2, 64'h0, lat);
      checkOutput("post_lat", 64'(lat),   64'd3);
      checkOutput("post_rd1", read_data1, 64'h1);
      checkOutput("post_rd2", read_data2, 64'h2);
      tick();

      $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
      $finish;
   end

endmodule

// File: doc/noun_mem_responder.md
# noun_mem_responder

Memory-side responder for the noun store: services the single-outstanding request protocol driven by the functional units (increment, traversal, execute) through the memory mux. It accepts a request on a rising edge of `mem_execute`, performs it against an internal single-port synchronous RAM, and returns a one-cycle `mem_ready` pulse with registered read data. It also owns the bump allocator that drives `free_addr`.

## Interface
Parameters:
- `ADDR_WIDTH`, default 10: RAM address width; depth = 2^ADDR_WIDTH words.
- `DATA_WIDTH`, default 64: word width (6 spare bits, hed_tag, tel_tag, 28-bit hed, 28-bit tel).
- `FREE_BASE`, default 1: reset value of `free_addr`. Address 0 is reserved for NIL.

Ports:
- `clk` input, 1: single clock; all state changes on the rising edge.
- `rst` input, 1: asynchronous, active-high reset.
- `mem_execute` input, 1: request strobe; only its rising edge is acted on.
- `mem_func` input, 2: 2'b00 NOP, 2'b01 GET_CONTENTS, 2'b10 SET_CONTENTS, 2'b11 ALLOC.
- `address1` input, ADDR_WIDTH: primary address (GET, SET).
- `address2` input, ADDR_WIDTH: secondary address (GET only).
- `write_data` input, DATA_WIDTH: word for SET/ALLOC.
- `mem_ready` output, 1: one-cycle completion pulse.
- `read_data1` output, DATA_WIDTH: GET: word at `address1`; ALLOC: allocated address, zero-extended.
- `read_data2` output, DATA_WIDTH: GET: word at `address2`; otherwise unchanged.
- `free_addr` output, ADDR_WIDTH: next address ALLOC will use.
- `mem_error` output, 2: sticky; bit0 = request dropped while busy, bit1 = ALLOC out of memory.

## Operation
- Edge detect: `exec_q` registers `mem_execute`. Accept = `mem_execute & ~exec_q & state==IDLE & mem_func!=NOP`. On accept, `mem_func`, `address1`, `address2`, `write_data` are latched; later input changes are ignored.
- Rising edge of `mem_execute` while state != IDLE: request is dropped and `mem_error[0]` is set. Rising edge with NOP in IDLE: ignored, no error.
- States: IDLE, RD1, RD2, WR, RESP.
  - GET: IDLE→RD1 (RAM address = a1)→RD2 (capture `read_data1`, RAM address = a2)→RESP (capture `read_data2`, `mem_ready`=1)→IDLE.
  - SET: IDLE→WR (write wd to a1)→RESP→IDLE.
  - ALLOC: IDLE→WR. If `free_addr` == 2^ADDR_WIDTH−1 and the top word is already used (tracked by a `full` flag), set `mem_error[1]` and do not write; `read_data1` = 0. Otherwise write wd at `free_addr`, `read_data1` = `free_addr`, then `free_addr`+1, saturating at the top address with `full`=1. Then →RESP→IDLE.
- `mem_ready` is registered and high only in RESP. `read_data1/2` hold until overwritten by a later GET/ALLOC.
- Address width: inputs are used as is; no range checking beyond ADDR_WIDTH.
- RAM contents are not cleared by reset.

## Timing
- Reset values: `mem_ready`=0, `read_data1`=0, `read_data2`=0, `free_addr`=FREE_BASE, `mem_error`=0, state=IDLE, `exec_q`=0, `full`=0.
- Accept edge E0. GET: `mem_ready` high from E3 to E4. SET/ALLOC: high from E2 to E3.
- A requester that sees `mem_ready` and raises `mem_execute` at the same edge is accepted at the next edge, because state is IDLE by then. The back-to-back request minimum period is 4 cycles for GET and 3 cycles for SET/ALLOC.
- Holding `mem_execute` high across several cycles is one request. A new request needs `mem_execute` low for at least one sampled edge.
- Reset asserted mid-request: the request is aborted immediately, no `mem_ready` is issued, and a partially issued write may or may not have landed.

## Test plan
- Reset: after `rst` pulse, check `free_addr`=1, `mem_ready`=0, `mem_error`=0, all read data 0.
- SET then GET: SET addr 5 = 64'h0000_0000_0000_0042, then SET addr 6 = 64'h00C0_0000_1000_0000. GET a1=5, a2=6 → `read_data1`=…42, `read_data2`=…00C0_…, `mem_ready` exactly one cycle at E3.
- ALLOC ×3 with wd = 1, 2, 3 → `read_data1` = 1, 2, 3; `free_addr` = 4. GET a1=2, a2=3 → 2, 3.
- Protocol stress: `mem_execute` held high 5 cycles → one response only. A second rising edge during RD1 → dropped, `mem_error[0]`=1, and the first response is still correct.
- Exhaustion (ADDR_WIDTH=3): 7 ALLOCs succeed (addresses 1..7), and the 8th sets `mem_error[1]`, returns 0, `free_addr` stays 7. Reset mid-GET (in RD2) → no `mem_ready`, and the outputs take their reset values.
